// File: rtl/comparator_pipe_if.sv
// Operand/result bundle for comparator_pipe.
// master drives operands, slave returns registered compare results.
interface comparator_pipe_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             signed_mode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             agb;
    logic             alb;
    logic             aeb;
    logic             change;
    logic             stable;

    modport master (
        output in_valid, signed_mode, a, b,
        input  out_valid, agb, alb, aeb, change, stable
    );

    modport slave (
        input  in_valid, signed_mode, a, b,
        output out_valid, agb, alb, aeb, change, stable
    );
endinterface

// File: rtl/comparator_pipe.sv
// One-cycle registered magnitude comparator with change
// pulse and run-length stability detection.
module comparator_pipe #(
    parameter int WIDTH      = 8,
    parameter int STABLE_CNT = 4
) (
    input logic             clk,
    input logic             reset,
    comparator_pipe_if.slave bus
);
    localparam logic [7:0] STABLE_MAX = 8'(STABLE_CNT);

    logic       gt;
    logic       lt;
    logic       eq;
    logic [2:0] res;
    logic [2:0] prev;
    logic       first;
    logic [7:0] cnt;
    logic [7:0] cnt_nxt;
    logic       diff;

    always_comb begin
        gt = 1'b0;
        lt = 1'b0;
        if (bus.signed_mode) begin
            gt = $signed(bus.a) > $signed(bus.b);
            lt = $signed(bus.a) < $signed(bus.b);
        end else begin
            gt = bus.a > bus.b;
            lt = bus.a < bus.b;
        end
        eq = bus.a == bus.b;
        res = {gt, lt, eq};
    end

    // first sample and result changes both restart the run
    always_comb begin
        diff = !first && (res != prev);
        if (first || diff)
            cnt_nxt = 8'd1;
        else if (cnt < STABLE_MAX)
            cnt_nxt = cnt + 8'd1;
        else
            cnt_nxt = cnt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bus.out_valid <= 1'b0;
            bus.agb       <= 1'b0;
            bus.alb       <= 1'b0;
            bus.aeb       <= 1'b0;
            bus.change    <= 1'b0;
            bus.stable    <= 1'b0;
            prev          <= 3'b000;
            cnt           <= 8'd0;
            first         <= 1'b1;
        end else if (bus.in_valid) begin
            bus.out_valid <= 1'b1;
            {bus.agb, bus.alb, bus.aeb} <= res;
            bus.change    <= diff;
            bus.stable    <= cnt_nxt == STABLE_MAX;
            prev          <= res;
            cnt           <= cnt_nxt;
            first         <= 1'b0;
        end else begin
            bus.out_valid <= 1'b0;
            bus.change    <= 1'b0;
        end
    end
endmodule

// File: tb/tb_comparator_pipe.sv
// Directed-vector bench for comparator_pipe.
// Output vector order: {out_valid, agb, alb, aeb, change, stable}.
module tb_comparator_pipe;
    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    comparator_pipe_if #(.WIDTH(8)) bus ();

    comparator_pipe #(
        .WIDTH      (8),
        .STABLE_CNT (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    logic [5:0] outs;
    assign outs = {bus.out_valid, bus.agb, bus.alb,
                   bus.aeb, bus.change, bus.stable};

    task automatic check(input string tag,
                         input logic [5:0] got,
                         input logic [5:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic cyc(input logic r, input logic v,
                       input logic m,
                       input logic [7:0] a, input logic [7:0] b,
                       input logic [5:0] exp, input string tag);
        reset           = r;
        bus.in_valid    = v;
        bus.signed_mode = m;
        bus.a           = a;
        bus.b           = b;
        @(posedge clk);
        #1;
        check(tag, outs, exp);
    endtask

    initial begin
        reset           = 1'b1;
        bus.in_valid    = 1'b0;
        bus.signed_mode = 1'b0;
        bus.a           = 8'h00;
        bus.b           = 8'h00;

        cyc(1, 0, 0, 8'h00, 8'h00, 6'b0_000_00, "rst1");
        cyc(1, 0, 0, 8'h00, 8'h00, 6'b0_000_00, "rst2");
        for (int i = 0; i < 3; i++)
            cyc(0, 0, 0, 8'h00, 8'h00, 6'b0_000_00, "idle");

        // mode sensitivity
        cyc(0, 1, 0, 8'hFF, 8'h01, 6'b1_100_00, "ff01_u");
        cyc(0, 1, 1, 8'hFF, 8'h01, 6'b1_010_10, "ff01_s");

        // boundaries
        cyc(0, 1, 0, 8'h80, 8'h80, 6'b1_001_10, "8080_u");
        cyc(0, 1, 1, 8'h80, 8'h80, 6'b1_001_00, "8080_s");
        cyc(0, 1, 1, 8'h7F, 8'h80, 6'b1_100_10, "7f80_s");
        cyc(0, 1, 0, 8'h7F, 8'h80, 6'b1_010_10, "7f80_u");
        cyc(0, 1, 0, 8'h00, 8'hFF, 6'b1_010_00, "00ff_u");

        // stability across gaps
        cyc(1, 0, 0, 8'h00, 8'h00, 6'b0_000_00, "rst3");
        cyc(0, 1, 0, 8'd5, 8'd3, 6'b1_100_00, "run1");
        cyc(0, 1, 0, 8'd5, 8'd3, 6'b1_100_00, "run2");
        for (int i = 0; i < 3; i++)
            cyc(0, 0, 0, 8'd0, 8'd0, 6'b0_100_00, "gap");
        cyc(0, 1, 0, 8'd5, 8'd3, 6'b1_100_00, "run3");
        cyc(0, 1, 0, 8'd5, 8'd3, 6'b1_100_01, "run4");

        // saturation, then break
        for (int i = 5; i <= 10; i++)
            cyc(0, 1, 0, 8'd5, 8'd3, 6'b1_100_01, "sat");
        cyc(0, 1, 0, 8'd3, 8'd5, 6'b1_010_10, "break");
        cyc(0, 0, 0, 8'd3, 8'd5, 6'b0_010_00, "hold");

        // reset mid-run wins over a valid sample
        cyc(1, 0, 0, 8'd0, 8'd0, 6'b0_000_00, "rst4");
        for (int i = 0; i < 3; i++)
            cyc(0, 1, 0, 8'd2, 8'd2, 6'b1_001_00, "eqrun");
        cyc(1, 1, 0, 8'd9, 8'd1, 6'b0_000_00, "rst_v");
        cyc(0, 1, 0, 8'd9, 8'd1, 6'b1_100_00, "post");
        cyc(0, 1, 0, 8'd9, 8'd1, 6'b1_100_00, "post2");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/comparator_pipe.md
COMPARATOR_PIPE -- requirements
Module: comparator_pipe

Interface
REQ-001 Parameter WIDTH, default 8, operand width in bits (legal >= 1).
REQ-002 Parameter STABLE_CNT, default 4, consecutive identical results needed to assert stable (legal 1..255).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  a, b and signed_mode are sampled this cycle.
REQ-006 signed_mode  input  1  0 = unsigned compare, 1 = two's-complement compare.
REQ-007 a  input  WIDTH  operand A.
REQ-008 b  input  WIDTH  operand B.
REQ-009 out_valid  output  1  registered result updated this cycle.
REQ-010 agb  output  1  registered A > B.
REQ-011 alb  output  1  registered A < B.
REQ-012 aeb  output  1  registered A == B.
REQ-013 change  output  1  one-cycle pulse: new result differs from previous result.
REQ-014 stable  output  1  result unchanged for STABLE_CNT consecutive valid samples.

Function
REQ-015 Latency: in_valid high at edge N SHALL produce out_valid high and updated agb/alb/aeb after edge N (one-cycle latency), full throughput of one sample per cycle.
REQ-016 in_valid low at an edge SHALL drive out_valid low next cycle; agb/alb/aeb, stable and the stability count SHALL hold.
REQ-017 After the first valid sample, exactly one of agb/alb/aeb SHALL be high at all times until reset.
REQ-018 signed_mode=0: operands compared as unsigned WIDTH-bit values; signed_mode=1: operands compared as signed WIDTH-bit two's complement; mode sampled per valid sample, no internal state depends on it.
REQ-019 Result code {agb,alb,aeb} SHALL be retained internally as the previous result for change detection.
REQ-020 change SHALL be high for exactly the cycle out_valid is high when the new result differs from the previous valid result; change SHALL be low for the first valid sample after reset and on all cycles with out_valid low.
REQ-021 Stability counter (8 bits): first valid sample after reset sets count to 1; a valid sample with same result as previous increments count, saturating at STABLE_CNT; a valid sample with a different result sets count to 1.
REQ-022 stable SHALL be registered high when count equals STABLE_CNT and low otherwise; with STABLE_CNT=1 stable SHALL be high from the first valid result on.
REQ-023 Gaps (in_valid low) SHALL NOT break the consecutive run; only valid samples are counted.
REQ-024 Change of signed_mode alone that flips the result SHALL be treated as a result change (change pulse, count to 1).

Reset
REQ-025 reset high at an edge SHALL force out_valid=0, agb=0, alb=0, aeb=0, change=0, stable=0, count=0, previous-result cleared, "first sample" flag set.
REQ-026 reset SHALL take priority over in_valid in the same cycle; the sample presented that cycle SHALL be discarded.
REQ-027 reset asserted mid-run SHALL discard the stability run; the next valid sample SHALL behave as first-after-reset (no change pulse, count=1).

Verification (WIDTH=8, STABLE_CNT=4)
REQ-028 Reset then idle: reset 2 cycles, in_valid=0 -> all outputs 0 indefinitely.
REQ-029 Mode: a=8'hFF, b=8'h01, signed_mode=0 -> next cycle agb=1,out_valid=1,change=0; same operands signed_mode=1 -> alb=1, change=1, stable=0.
REQ-030 Boundaries: a=b=8'h80 -> aeb=1 both modes; a=8'h7F,b=8'h80 signed -> agb=1; unsigned -> alb=1; a=8'h00,b=8'hFF unsigned -> alb=1.
REQ-031 Stability with gaps: a=5,b=3 valid on cycles 1,2, idle 3 cycles, valid cycles 6,7 -> stable rises after 4th valid sample (after edge 7), change never pulses, stable stays high on further a=5,b=3.
REQ-032 Saturation and break: 10 consecutive a=5,b=3 then a=3,b=5 -> stable held high samples 4..10, then alb=1, change=1, stable=0 same cycle.
REQ-033 Reset mid-run: 3 valid a=2,b=2 then reset concurrent with in_valid (a=9,b=1) -> outputs all 0; next valid a=9,b=1 -> agb=1, change=0, stable=0.
